spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Mode-0 SPI master that reads one 32-bit {X,Y} tracking frame from the FPGA-side
//  spi_slave. Sits on the consumer side (motor-control domain / bring-up bench), drives cs/sclk/mosi.
//  Samples miso and presents xdata_rx/ydata_rx with a done pulse per frame.
//  Frame timing meets the slave's cs synchroniser and its PREP latency.
// PARAMETERS
//  CLK_DIV   8   sclk half-period in clk cycles; legal >= 6 (slave miso update + 2-flop sync)
//  CS_SETUP  16  clk cycles from cs fall to first sclk rise; legal >= 8 (slave sync + PREP)
//  CS_HOLD   8   clk cycles from last sclk fall to cs rise; also min cs-high gap; legal >= 2
//  Illegal values -> elaboration-time $error.
// PORTS
//  clk       in   1   system clock
//  reset     in   1   asynchronous, active-high
//  start     in   1   request one frame; sampled only in IDLE
//  tx_data   in   32  word shifted out on mosi, MSB first (slave ignores it; kept for loopback)
//  busy      out  1   high from cycle after accepted start through end of GAP
//  done      out  1   1-cycle pulse, rx valid
//  rx_data   out  32  last received frame {x,y}; held until next done
//  xdata_rx  out  16  rx_data[31:16]
//  ydata_rx  out  16  rx_data[15:0]
//  sclk      out  1   SPI clock, idle low (CPOL=0)
//  mosi      out  1   SPI data out, changes on sclk fall
//  cs        out  1   chip select, active low
//  miso      in   1   SPI data in; 2-flop synchronised internally
// BEHAVIOUR
//  Reset: cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0; FSM->IDLE; shift regs/counters cleared.
//  All SPI outputs are registered (glitch-free). miso passes through a 2-flop sync (miso_s).
//  FSM: IDLE -> SETUP -> LOW <-> HIGH -> HOLD -> GAP -> IDLE.
//   IDLE : start=1 at cycle T -> at T+1 cs=0, busy=1, mosi=tx_data[31], load tx shift reg. Go SETUP.
//   SETUP: count CS_SETUP-1 cycles with sclk=0; then sclk=1 (rise 1), sample miso_s, go HIGH.
//   HIGH : after CLK_DIV cycles, sclk=0 (fall). If bit_cnt==31: mosi=0, go HOLD.
//          Else mosi=next tx bit, go LOW.
//   LOW  : after CLK_DIV cycles, sclk=1 (rise), shift miso_s into rx shift reg LSB, bit_cnt++. Go HIGH.
//   HOLD : CS_HOLD cycles, cs=0, sclk=0. Then cs=1, rx_data<=rx shift, done=1 (same cycle). Go GAP.
//   GAP  : CS_HOLD cycles with cs=1, busy=1. Then busy=0, go IDLE.
//  Edge timing relative to cs fall (cycle 0):
//   rise k at CS_SETUP+(k-1)*2*CLK_DIV; fall k at rise k + CLK_DIV.
//   cs rise at CS_SETUP+63*CLK_DIV+CS_HOLD (defaults: 528).
//  Bit order: first miso bit sampled = rx_data[31] = xdata bit 15. Exactly 32 rises and 32 falls per frame.
//  start while busy=1 (any state but IDLE) is ignored and not queued.
//  start held high continuously -> back-to-back frames, each separated by >= CS_HOLD cycles of cs high.
//  Reset mid-frame: outputs go to reset values immediately (async), no done.
//   The slave recovers via its cs rise.
//  rx_data/xdata_rx/ydata_rx update only on done; partial frames are never exposed.
// TESTING (bench: spi_master wired to spi_slave, same clk/reset, default params)
//  1 x=0x1234, y=0xABCD, pulse start -> one done; rx_data=0x1234ABCD; 32 sclk rises; cs low 528 cycles.
//  2 x=0xAAAA/y=0x5555, then x=0xFFFF/y=0x0000 with start held high ->
//    done twice, rx 0xAAAA5555 then 0xFFFF0000; cs-high gap >= 8 cycles.
//  3 Pulse start at cycles 1, 100 and 300 of a frame -> only the first accepted; single done; busy unbroken.
//  4 Assert reset at rise 10 -> cs=1, sclk=0, busy=0 same cycle; no done.
//    A new frame after release returns the correct x/y.
//  5 Checker: sclk changes only while cs=0; mosi stable across every sclk rise.
//    First rise exactly CS_SETUP cycles after cs fall.
//  6 Idle check: reset released, start=0 for 1000 cycles -> cs=1, sclk=0, busy=0, done never pulses.

Source files
------------

// File: rtl/spi_master.sv
// Mode-0 SPI master: reads one 32-bit {X,Y} frame per start request.
// All SPI outputs are registered; miso is brought in through a 2-flop synchroniser.
module spi_master #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 16,
  parameter int CS_HOLD  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_data,
  output logic [15:0] xdata_rx,
  output logic [15:0] ydata_rx,
  output logic        sclk,
  output logic        mosi,
  output logic        cs,
  input  logic        miso
);

  if (CLK_DIV < 6) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be >= 6");
  end
  if (CS_SETUP < 8) begin : g_bad_cs_setup
    $error("spi_master: CS_SETUP must be >= 8");
  end
  if (CS_HOLD < 2) begin : g_bad_cs_hold
    $error("spi_master: CS_HOLD must be >= 2");
  end

  // One shared down-the-phase counter sized for the longest phase.
  localparam int MAXC = (CS_SETUP > CLK_DIV) ? ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD)
                                             : ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD);
  localparam int CNT_W = $clog2(MAXC);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [31:0]       tx_sh_q, tx_sh_d;
  logic [31:0]       rx_sh_q, rx_sh_d;
  logic [31:0]       rx_data_q, rx_data_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              miso_s1_q, miso_s_q;

  // Two-flop synchroniser for the asynchronous miso line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_s1_q <= 1'b0;
      miso_s_q  <= 1'b0;
    end else begin
      miso_s1_q <= miso;
      miso_s_q  <= miso_s1_q;
    end
  end

  // State, counters, shift registers and registered SPI outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; every edge is decided one cycle ahead.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          mosi_d    = tx_data[31];
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[30:0], miso_s_q};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_cnt_q == 5'd31) begin
            mosi_d  = 1'b0;
            state_d = S_HOLD;
          end else begin
            mosi_d  = tx_sh_q[30];
            tx_sh_d = tx_sh_q << 1;
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          sclk_d    = 1'b1;
          rx_sh_d   = {rx_sh_q[30:0], miso_s_q};
          bit_cnt_d = bit_cnt_q + 5'd1;
          state_d   = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          cs_d      = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cs       = cs_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign xdata_rx = rx_data_q[31:16];
  assign ydata_rx = rx_data_q[15:0];

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave feeds miso, a monitor measures
// edge timing, and every received word is compared with the frame the slave sent.
module tb_spi_master;

  localparam int CLK_DIV  = 8;
  localparam int CS_SETUP = 16;
  localparam int CS_HOLD  = 8;
  localparam int CS_LOW_LEN = CS_SETUP + 63 * CLK_DIV + CS_HOLD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] tx_data = '0;
  logic        busy, done, sclk, mosi, cs;
  logic        miso = 1'b0;
  logic [31:0] rx_data;
  logic [15:0] xdata_rx, ydata_rx;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .xdata_rx(xdata_rx),
    .ydata_rx(ydata_rx), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave frame and monitor statistics
  logic [31:0] frame = '0;
  int sidx = 31;
  int cs_fall_cyc = 0, cs_rise_cyc = -1, cs_low_len = 0, first_rise_off = -1;
  int rise_cnt = 0, fall_cnt = 0, viol = 0, done_cnt = 0, cs_fall_cnt = 0;
  int busy_fall_cnt = 0, min_gap = 1000000;
  logic [31:0] mosi_word = '0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;

  // Slave model (shifts frame out MSB first, advancing after each sclk fall) and protocol monitor.
  always @(negedge clk) begin
    if (prev_cs && !cs) begin
      cs_fall_cnt++;
      cs_fall_cyc = cyc;
      rise_cnt = 0;
      fall_cnt = 0;
      first_rise_off = -1;
      mosi_word = '0;
      if (cs_rise_cyc >= 0 && (cyc - cs_rise_cyc) < min_gap) min_gap = cyc - cs_rise_cyc;
      sidx = 31;
      miso = frame[31];
    end
    if (!prev_cs && cs) begin
      cs_low_len = cyc - cs_fall_cyc;
      cs_rise_cyc = cyc;
    end
    if (!prev_sclk && sclk) begin
      rise_cnt++;
      if (rise_cnt == 1) first_rise_off = cyc - cs_fall_cyc;
      mosi_word = {mosi_word[30:0], mosi};
      if (mosi !== prev_mosi) viol++;
    end
    if (prev_sclk && !sclk) begin
      fall_cnt++;
      if (!cs && sidx > 0) begin
        sidx--;
        miso = frame[sidx];
      end
    end
    if (sclk !== prev_sclk && cs && prev_cs) viol++;
    if (done === 1'b1) done_cnt++;
    if (prev_busy && !busy) busy_fall_cnt++;
    prev_cs = cs;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 3000) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
      n++;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 3000) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
      n++;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One complete frame with full timing and data checks.
  task automatic run_frame(input logic [15:0] x, input logic [15:0] y,
                           input logic [31:0] tx, input string tag);
    int d0;
    wait_idle({tag, "_idle"});
    frame = {x, y};
    tx_data = tx;
    d0 = done_cnt;
    pulse_start();
    wait_done({tag, "_done"});
    repeat (3) @(negedge clk);
    chk({tag, "_rx"}, rx_data, {x, y});
    chk({tag, "_x"}, 32'(xdata_rx), 32'(x));
    chk({tag, "_y"}, 32'(ydata_rx), 32'(y));
    chk({tag, "_rises"}, 32'(rise_cnt), 32'd32);
    chk({tag, "_falls"}, 32'(fall_cnt), 32'd32);
    chk({tag, "_cs_low"}, 32'(cs_low_len), 32'(CS_LOW_LEN));
    chk({tag, "_first_rise"}, 32'(first_rise_off), 32'(CS_SETUP));
    chk({tag, "_mosi"}, mosi_word, tx);
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_viol"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int d0, f0, b0, r;
    logic p;
    logic [31:0] rnd;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", rx_data, 32'd0);
    reset = 1'b0;

    // Idle: no start for 1000 cycles
    d0 = done_cnt;
    f0 = cs_fall_cnt;
    repeat (1000) @(negedge clk);
    chk("idle_cs", 32'(cs), 32'd1);
    chk("idle_sclk", 32'(sclk), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done_cnt - d0), 32'd0);
    chk("idle_cs_falls", 32'(cs_fall_cnt - f0), 32'd0);

    // Directed frame, then randomized frames
    run_frame(16'h1234, 16'hABCD, $urandom, "f1");
    for (int i = 0; i < 3; i++) begin
      rnd = $urandom;
      run_frame(rnd[31:16], rnd[15:0], $urandom, $sformatf("rnd%0d", i));
    end

    // Back-to-back frames with start held high
    wait_idle("b2b_idle");
    min_gap = 1000000;
    f0 = cs_fall_cnt;
    frame = 32'hAAAA5555;
    tx_data = $urandom;
    start = 1'b1;
    wait_done("b2b_done1");
    chk("b2b_rx1", rx_data, 32'hAAAA5555);
    frame = 32'hFFFF0000;
    wait_done("b2b_done2");
    start = 1'b0;
    chk("b2b_rx2", rx_data, 32'hFFFF0000);
    wait_idle("b2b_idle2");
    repeat (30) @(negedge clk);
    chk("b2b_gap_ge_hold", 32'(min_gap >= CS_HOLD), 32'd1);
    chk("b2b_frames", 32'(cs_fall_cnt - f0), 32'd2);

    // Start pulses while busy are ignored
    wait_idle("ign_idle");
    rnd = $urandom;
    frame = rnd;
    tx_data = $urandom;
    f0 = cs_fall_cnt;
    b0 = busy_fall_cnt;
    d0 = done_cnt;
    pulse_start();
    pulse_start();
    repeat (98) @(negedge clk);
    pulse_start();
    repeat (199) @(negedge clk);
    pulse_start();
    wait_done("ign_done");
    wait_idle("ign_idle2");
    repeat (30) @(negedge clk);
    chk("ign_rx", rx_data, rnd);
    chk("ign_frames", 32'(cs_fall_cnt - f0), 32'd1);
    chk("ign_dones", 32'(done_cnt - d0), 32'd1);
    chk("ign_busy_falls", 32'(busy_fall_cnt - b0), 32'd1);

    // Reset in the middle of a frame, at the tenth sclk rise
    wait_idle("mid_idle");
    frame = $urandom;
    tx_data = $urandom;
    d0 = done_cnt;
    pulse_start();
    r = 0;
    p = sclk;
    for (int n = 0; n < 2000 && r < 10; n++) begin
      @(negedge clk);
      if (sclk && !p) r++;
      p = sclk;
    end
    chk("mid_reached_rise10", 32'(r), 32'd10);
    reset = 1'b1;
    #1;
    chk("mid_cs", 32'(cs), 32'd1);
    chk("mid_sclk", 32'(sclk), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rx_cleared", rx_data, 32'd0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    rnd = $urandom;
    run_frame(rnd[31:16], rnd[15:0], $urandom, "after_rst");

    chk("protocol_viol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
